// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master/two-slave bus arbiter: state encoding,
// default address map and the address-window match helper.
package bus_arbiter_pkg;

  typedef enum logic {
    GRANT_M0 = 1'b0,
    GRANT_M1 = 1'b1
  } arb_state_e;

  localparam logic [7:0] S0_BASE_DEF  = 8'h00;
  localparam logic [7:0] S0_MASK_DEF  = 8'hE0;
  localparam logic [7:0] S1_BASE_DEF  = 8'h20;
  localparam logic [7:0] S1_MASK_DEF  = 8'hE0;
  localparam int         MAX_HOLD_DEF = 16;

  // Read-return select codes, {S1_sel, S0_sel} as captured one cycle earlier.
  localparam logic [1:0] RSEL_NONE = 2'b00;
  localparam logic [1:0] RSEL_S0   = 2'b01;
  localparam logic [1:0] RSEL_S1   = 2'b10;

  function automatic logic addr_hit(input logic [7:0] addr,
                                    input logic [7:0] base,
                                    input logic [7:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational address decode to one-hot slave selects; slave 0 wins on overlap,
// unmapped addresses select nothing.
module bus_addr_decoder
  import bus_arbiter_pkg::*;
#(
  parameter logic [7:0] S0_BASE = S0_BASE_DEF,
  parameter logic [7:0] S0_MASK = S0_MASK_DEF,
  parameter logic [7:0] S1_BASE = S1_BASE_DEF,
  parameter logic [7:0] S1_MASK = S1_MASK_DEF
) (
  input  logic       req,
  input  logic [7:0] address,
  output logic [1:0] sel
);

  logic s0_hit;
  logic s1_hit;

  always_comb begin
    s0_hit = addr_hit(address, S0_BASE, S0_MASK);
    s1_hit = addr_hit(address, S1_BASE, S1_MASK);
    sel    = 2'b00;
    if (req) begin
      sel[0] = s0_hit;
      sel[1] = s1_hit & ~s0_hit;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter with starvation guard for M0, address decode to two slaves,
// and a registered read-return select matching the slaves' one-cycle read latency.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter logic [7:0] S0_BASE  = S0_BASE_DEF,
  parameter logic [7:0] S0_MASK  = S0_MASK_DEF,
  parameter logic [7:0] S1_BASE  = S1_BASE_DEF,
  parameter logic [7:0] S1_MASK  = S1_MASK_DEF,
  parameter int         MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        M0_req,
  input  logic        M0_wr,
  input  logic [7:0]  M0_address,
  input  logic [31:0] M0_dout,
  input  logic        M1_req,
  input  logic        M1_wr,
  input  logic [7:0]  M1_address,
  input  logic [31:0] M1_dout,
  input  logic [31:0] S0_dout,
  input  logic [31:0] S1_dout,
  output logic        M0_grant,
  output logic        M1_grant,
  output logic [31:0] M_din,
  output logic        S0_sel,
  output logic        S1_sel,
  output logic [7:0]  S_address,
  output logic        S_wr,
  output logic [31:0] S_din
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_e    state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          m0_grant_q, m1_grant_q;
  logic [1:0]    rsel_q;
  logic [1:0]    sel;
  logic          req_g;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      GRANT_M0: begin
        hold_cnt_d = '0;
        if (!M0_req && M1_req) state_d = GRANT_M1;
      end
      GRANT_M1: begin
        if (!M1_req || (M0_req && hold_cnt_q == HOLD_LAST)) begin
          state_d    = GRANT_M0;
          hold_cnt_d = '0;
        end else if (M0_req && hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = GRANT_M0;
        hold_cnt_d = '0;
      end
    endcase
  end

  // Grants are registered from the next state so they always mirror state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= GRANT_M0;
      hold_cnt_q <= '0;
      m0_grant_q <= 1'b1;
      m1_grant_q <= 1'b0;
      rsel_q     <= RSEL_NONE;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      m0_grant_q <= (state_d == GRANT_M0);
      m1_grant_q <= (state_d == GRANT_M1);
      rsel_q     <= sel;
    end
  end

  always_comb begin
    if (state_q == GRANT_M1) begin
      req_g     = M1_req;
      S_address = M1_address;
      S_wr      = M1_wr;
      S_din     = M1_dout;
    end else begin
      req_g     = M0_req;
      S_address = M0_address;
      S_wr      = M0_wr;
      S_din     = M0_dout;
    end
  end

  bus_addr_decoder #(
    .S0_BASE (S0_BASE),
    .S0_MASK (S0_MASK),
    .S1_BASE (S1_BASE),
    .S1_MASK (S1_MASK)
  ) u_decoder (
    .req     (req_g),
    .address (S_address),
    .sel     (sel)
  );

  // Return path keys off the select captured last cycle, so a grant change
  // in the data cycle cannot redirect it.
  always_comb begin
    case (rsel_q)
      RSEL_S0: M_din = S0_dout;
      RSEL_S1: M_din = S1_dout;
      default: M_din = '0;
    endcase
  end

  assign S0_sel   = sel[0];
  assign S1_sel   = sel[1];
  assign M0_grant = m0_grant_q;
  assign M1_grant = m1_grant_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a driver applies directed and random cycles and
// queues the behaviourally-predicted outputs; a monitor pops and compares each cycle.
module tb_bus_arbiter;

  localparam int MAX_HOLD = 16;

  logic        clk;
  logic        reset_n;
  logic        M0_req, M0_wr, M1_req, M1_wr;
  logic [7:0]  M0_address, M1_address;
  logic [31:0] M0_dout, M1_dout, S0_dout, S1_dout;
  logic        M0_grant, M1_grant, S0_sel, S1_sel, S_wr;
  logic [31:0] M_din, S_din;
  logic [7:0]  S_address;

  typedef struct packed {
    logic        m0g;
    logic        m1g;
    logic        s0s;
    logic        s1s;
    logic [7:0]  addr;
    logic        wr;
    logic [31:0] din;
    logic [31:0] mdin;
  } obs_t;

  obs_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;

  // Reference model: who owns the bus, how long M0 has been kept waiting,
  // and which slave (0 none, 1 S0, 2 S1) was addressed last cycle.
  int owner    = 0;
  int wait_cnt = 0;
  int prev_tgt = 0;

  bus_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .M0_req     (M0_req),
    .M0_wr      (M0_wr),
    .M0_address (M0_address),
    .M0_dout    (M0_dout),
    .M1_req     (M1_req),
    .M1_wr      (M1_wr),
    .M1_address (M1_address),
    .M1_dout    (M1_dout),
    .S0_dout    (S0_dout),
    .S1_dout    (S1_dout),
    .M0_grant   (M0_grant),
    .M1_grant   (M1_grant),
    .M_din      (M_din),
    .S0_sel     (S0_sel),
    .S1_sel     (S1_sel),
    .S_address  (S_address),
    .S_wr       (S_wr),
    .S_din      (S_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int target(input logic req, input logic [7:0] a);
    if (!req)   return 0;
    if (a < 32) return 1;
    if (a < 64) return 2;
    return 0;
  endfunction

  task automatic cycle(input logic rst_n,
                       input logic q0, input logic w0, input logic [7:0] a0, input logic [31:0] d0,
                       input logic q1, input logic w1, input logic [7:0] a1, input logic [31:0] d1);
    obs_t e;
    int   t;
    logic rq;
    @(negedge clk);
    reset_n    = rst_n;
    M0_req     = q0;  M0_wr = w0;  M0_address = a0;  M0_dout = d0;
    M1_req     = q1;  M1_wr = w1;  M1_address = a1;  M1_dout = d1;
    S0_dout    = $urandom;
    S1_dout    = $urandom;
    if (!rst_n) begin
      owner    = 0;
      wait_cnt = 0;
      prev_tgt = 0;
    end
    e.m0g  = (owner == 0);
    e.m1g  = (owner == 1);
    rq     = (owner == 1) ? q1 : q0;
    e.addr = (owner == 1) ? a1 : a0;
    e.wr   = (owner == 1) ? w1 : w0;
    e.din  = (owner == 1) ? d1 : d0;
    t      = target(rq, e.addr);
    e.s0s  = (t == 1);
    e.s1s  = (t == 2);
    e.mdin = (prev_tgt == 1) ? S0_dout : (prev_tgt == 2) ? S1_dout : 32'h0;
    sb_q.push_back(e);
    if (rst_n) begin
      prev_tgt = t;
      if (owner == 0) begin
        if (!q0 && q1) begin
          owner    = 1;
          wait_cnt = 0;
        end
      end else if (!q1) begin
        owner = 0;
      end else if (q0) begin
        wait_cnt++;
        if (wait_cnt == MAX_HOLD) owner = 0;
      end
    end
  endtask

  task automatic idle_cycle(input logic rst_n, input logic q1, input logic [7:0] a1);
    cycle(rst_n, 1'b0, 1'b0, 8'h00, 32'h0, q1, 1'b0, a1, 32'h0);
  endtask

  task automatic rnd_cycle(input int p0, input int p1);
    logic [7:0] a0, a1;
    a0 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 63));
    a1 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 63));
    cycle(1'b1,
          ($urandom_range(0, 99) < p0), 1'($urandom), a0, $urandom,
          ($urandom_range(0, 99) < p1), 1'($urandom), a1, $urandom);
  endtask

  // Monitor: sample well after the driving edge and well before the next rising edge.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = '{M0_grant, M1_grant, S0_sel, S1_sel, S_address, S_wr, S_din, M_din};
        n_checks++;
        n_txn++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL txn %0d outputs: got g=%b%b sel=%b%b addr=%h wr=%b din=%h mdin=%h, want g=%b%b sel=%b%b addr=%h wr=%b din=%h mdin=%h",
                   n_txn, a.m0g, a.m1g, a.s1s, a.s0s, a.addr, a.wr, a.din, a.mdin,
                   e.m0g, e.m1g, e.s1s, e.s0s, e.addr, e.wr, e.din, e.mdin);
        end else begin
          $display("txn %0d ok: g=%b%b sel=%b%b addr=%h wr=%b mdin=%h",
                   n_txn, a.m0g, a.m1g, a.s1s, a.s0s, a.addr, a.wr, a.mdin);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    M0_req = 1'b0; M0_wr = 1'b0; M0_address = 8'h00; M0_dout = 32'h0;
    M1_req = 1'b1; M1_wr = 1'b0; M1_address = 8'h21; M1_dout = 32'h0;
    S0_dout = 32'h0; S1_dout = 32'h0;

    // Reset with M1 requesting, then release: M1 granted one cycle later.
    repeat (3) idle_cycle(1'b0, 1'b1, 8'h21);
    idle_cycle(1'b1, 1'b1, 8'h21);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 8'h21, 32'h1234_5678);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h21, 32'h0);

    // M1 releases, M0 writes then reads 8'h05.
    cycle(1'b1, 1'b1, 1'b1, 8'h05, 32'hDEAD_BEEF, 1'b0, 1'b0, 8'h00, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 8'h05, 32'hDEAD_BEEF, 1'b0, 1'b0, 8'h00, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 8'h05, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 8'h05, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);

    // Unmapped read: no select, zero returned.
    cycle(1'b1, 1'b1, 1'b0, 8'h80, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 8'h80, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);

    // Simultaneous requests: M0 keeps the bus.
    repeat (10) cycle(1'b1, 1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 1'b1, 8'h22, 32'h5);

    // Starvation guard, run twice to show the counter restarts from zero.
    repeat (2) begin
      repeat (2) cycle(1'b1, 1'b0, 1'b0, 8'h10, 32'h0, 1'b1, 1'b1, 8'h23, 32'h7);
      repeat (20) cycle(1'b1, 1'b1, 1'b0, 8'h11, 32'h0, 1'b1, 1'b0, 8'h23, 32'h0);
    end

    // M1 read burst interrupted by reset.
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h22, 32'h0);
    repeat (2) idle_cycle(1'b0, 1'b1, 8'h22);
    repeat (3) idle_cycle(1'b1, 1'b1, 8'h22);

    // Randomized segments with varying request pressure.
    for (int seg = 0; seg < 30; seg++) begin
      int p0, p1;
      p0 = $urandom_range(10, 95);
      p1 = $urandom_range(40, 100);
      repeat (40) rnd_cycle(p0, p1);
    end

    repeat (2) @(negedge clk);
    #5;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
